// File: rtl/bolme_pkg.sv
// Shared definitions for the 32-bit iterative divider: op encodings, FSM states
// and the sign-magnitude helpers used on the operand and result paths.
package bolme_pkg;

  localparam int GENISLIK = 32;

  localparam logic [1:0] ISLEM_DIVU = 2'b00;
  localparam logic [1:0] ISLEM_REMU = 2'b01;
  localparam logic [1:0] ISLEM_DIV  = 2'b10;
  localparam logic [1:0] ISLEM_REM  = 2'b11;

  typedef enum logic {
    BOS    = 1'b0,
    MESGUL = 1'b1
  } durum_t;

  function automatic logic [GENISLIK-1:0] eksi(input logic [GENISLIK-1:0] x);
    eksi = 32'd0 - x;
  endfunction

  function automatic logic [GENISLIK-1:0] mutlak(input logic [GENISLIK-1:0] x,
                                                 input logic isaretli);
    if (isaretli && x[GENISLIK-1]) begin
      mutlak = eksi(x);
    end else begin
      mutlak = x;
    end
  endfunction

endpackage

// File: rtl/bolme_birimi_32.sv
// Radix-2 restoring divider for RV32M DIVU/REMU/DIV/REM: one quotient bit per
// clock, fixed 32-cycle latency, registered result with a one-cycle done pulse.
module bolme_birimi_32
  import bolme_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                basla_i,
  input  logic [1:0]          islem_i,
  input  logic [GENISLIK-1:0] bolunen_i,
  input  logic [GENISLIK-1:0] bolen_i,
  output logic [GENISLIK-1:0] sonuc_o,
  output logic                bitti_o
);

  durum_t                  durum_r;
  durum_t                  durum_sonraki_s;
  logic                    kabul_s;
  logic                    bitir_s;
  logic [5:0]              sayac_r;
  logic [2*GENISLIK-1:0]   kaydirma_r;
  logic [GENISLIK-1:0]     bolen_r;
  logic                    kalan_sec_r;
  logic                    neg_bolum_r;
  logic                    neg_kalan_r;
  logic [GENISLIK-1:0]     sonuc_r;
  logic                    bitti_r;

  logic                    isaretli_s;
  logic                    kalan_istek_s;
  logic [GENISLIK:0]       fark_s;
  logic [2*GENISLIK-1:0]   sonraki_s;
  logic [GENISLIK-1:0]     sonuc_hesap_s;

  assign isaretli_s    = (islem_i == ISLEM_DIV) || (islem_i == ISLEM_REM);
  assign kalan_istek_s = !((islem_i == ISLEM_DIVU) || (islem_i == ISLEM_DIV));

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      durum_r <= BOS;
    end else begin
      durum_r <= durum_sonraki_s;
    end
  end

  // Next-state logic, accept and completion strobes
  always_comb begin
    durum_sonraki_s = durum_r;
    kabul_s         = 1'b0;
    bitir_s         = 1'b0;
    case (durum_r)
      BOS: begin
        if (basla_i) begin
          durum_sonraki_s = MESGUL;
          kabul_s         = 1'b1;
        end else begin
          durum_sonraki_s = BOS;
        end
      end
      MESGUL: begin
        if (sayac_r == 6'd1) begin
          durum_sonraki_s = BOS;
          bitir_s         = 1'b1;
        end else begin
          durum_sonraki_s = MESGUL;
        end
      end
      default: begin
        durum_sonraki_s = BOS;
      end
    endcase
  end

  // One restoring step; the 33-bit difference sign decides the quotient bit.
  // A zero divisor makes every subtraction succeed, giving all-ones quotient and
  // the untouched dividend magnitude as remainder.
  always_comb begin
    fark_s = kaydirma_r[2*GENISLIK-1:GENISLIK-1] - {1'b0, bolen_r};
    if (!fark_s[GENISLIK]) begin
      sonraki_s = {fark_s[GENISLIK-1:0], kaydirma_r[GENISLIK-2:0], 1'b1};
    end else begin
      sonraki_s = {kaydirma_r[2*GENISLIK-2:0], 1'b0};
    end
  end

  // Sign fix-up of the final step's quotient or remainder
  always_comb begin
    if (kalan_sec_r) begin
      if (neg_kalan_r) begin
        sonuc_hesap_s = eksi(sonraki_s[2*GENISLIK-1:GENISLIK]);
      end else begin
        sonuc_hesap_s = sonraki_s[2*GENISLIK-1:GENISLIK];
      end
    end else begin
      if (neg_bolum_r) begin
        sonuc_hesap_s = eksi(sonraki_s[GENISLIK-1:0]);
      end else begin
        sonuc_hesap_s = sonraki_s[GENISLIK-1:0];
      end
    end
  end

  // Datapath registers: operand capture, iteration and result
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sayac_r     <= 6'd0;
      kaydirma_r  <= 64'd0;
      bolen_r     <= 32'd0;
      kalan_sec_r <= 1'b0;
      neg_bolum_r <= 1'b0;
      neg_kalan_r <= 1'b0;
      sonuc_r     <= 32'd0;
      bitti_r     <= 1'b0;
    end else begin
      bitti_r <= bitir_s;
      if (kabul_s) begin
        sayac_r     <= 6'd32;
        kaydirma_r  <= {32'd0, mutlak(bolunen_i, isaretli_s)};
        bolen_r     <= mutlak(bolen_i, isaretli_s);
        kalan_sec_r <= kalan_istek_s;
        // Divide-by-zero keeps the all-ones quotient unsigned-looking
        neg_bolum_r <= isaretli_s && (bolunen_i[GENISLIK-1] ^ bolen_i[GENISLIK-1])
                       && (bolen_i != 32'd0);
        neg_kalan_r <= isaretli_s && bolunen_i[GENISLIK-1];
      end else if (durum_r == MESGUL) begin
        sayac_r    <= sayac_r - 6'd1;
        kaydirma_r <= sonraki_s;
        if (bitir_s) begin
          sonuc_r <= sonuc_hesap_s;
        end else begin
          sonuc_r <= sonuc_r;
        end
      end else begin
        sayac_r <= sayac_r;
      end
    end
  end

  assign sonuc_o = sonuc_r;
  assign bitti_o = bitti_r;

endmodule

// File: tb/tb_bolme_birimi_32.sv
// Directed self-checking bench for bolme_birimi_32: hand-computed RV32M results,
// latency, back-to-back acceptance, operand latching and mid-operation reset.
module tb_bolme_birimi_32;

  logic        clk_i;
  logic        rst_i;
  logic        basla_i;
  logic [1:0]  islem_i;
  logic [31:0] bolunen_i;
  logic [31:0] bolen_i;
  logic [31:0] sonuc_o;
  logic        bitti_o;

  int checks_s;
  int errors_s;

  bolme_birimi_32 dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .basla_i   (basla_i),
    .islem_i   (islem_i),
    .bolunen_i (bolunen_i),
    .bolen_i   (bolen_i),
    .sonuc_o   (sonuc_o),
    .bitti_o   (bitti_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  localparam int NV = 20;
  logic [1:0]  v_islem [NV] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01,
                                2'b10, 2'b10, 2'b11, 2'b11, 2'b10, 2'b11,
                                2'b00, 2'b10, 2'b01, 2'b11, 2'b10, 2'b11,
                                2'b10, 2'b11};
  logic [31:0] v_a [NV] = '{32'd41, 32'd41, 32'hFFFF_FFD7, 32'hFFFF_FFD7, 32'd41, 32'd41,
                            32'hFFFF_FFD7, 32'd41, 32'hFFFF_FFD7, 32'd41, 32'd9, 32'd9,
                            32'd41, 32'd41, 32'd41, 32'd41, 32'h8000_0000, 32'h8000_0000,
                            32'hFFFF_FFD7, 32'hFFFF_FFD7};
  logic [31:0] v_b [NV] = '{32'd9, 32'd9, 32'd9, 32'd9, 32'hFFFF_FFF7, 32'hFFFF_FFF7,
                            32'd9, 32'hFFFF_FFF7, 32'd9, 32'hFFFF_FFF7, 32'd41, 32'd41,
                            32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            32'd0, 32'd0};
  logic [31:0] v_q [NV] = '{32'd4, 32'd5, 32'd477218583, 32'd8, 32'd0, 32'd41,
                            32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFFB, 32'd5, 32'd0, 32'd9,
                            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd41, 32'd41, 32'h8000_0000, 32'd0,
                            32'hFFFF_FFFF, 32'hFFFF_FFD7};

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                         input logic [31:0] beklenen);
    checks_s++;
    if (gozlenen !== beklenen) begin
      errors_s++;
      $display("FAIL %s observed=%h expected=%h", etiket, gozlenen, beklenen);
    end
  endtask

  // Waits (bounded) for bitti_o, sampling 1 time unit after each rising edge
  task automatic bekle(output int n);
    n = 0;
    while (n < 40 && bitti_o !== 1'b1) begin
      @(posedge clk_i);
      #1;
      n++;
    end
  endtask

  task automatic calistir(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] beklenen, input string etiket);
    int n;
    @(negedge clk_i);
    islem_i = op; bolunen_i = a; bolen_i = b; basla_i = 1'b1;
    @(posedge clk_i);
    #1;
    basla_i = 1'b0; islem_i = ~op; bolunen_i = ~a; bolen_i = ~b;
    bekle(n);
    kontrol({etiket, "_lat"}, 32'(n), 32'd32);
    kontrol({etiket, "_res"}, sonuc_o, beklenen);
    @(posedge clk_i);
    #1;
    kontrol({etiket, "_pulse"}, {31'd0, bitti_o}, 32'd0);
    kontrol({etiket, "_hold"}, sonuc_o, beklenen);
  endtask

  initial begin
    int n;
    int darbe;
    checks_s = 0; errors_s = 0;
    rst_i = 1'b0; basla_i = 1'b0; islem_i = 2'b00; bolunen_i = 32'd0; bolen_i = 32'd0;
    repeat (3) @(posedge clk_i);
    #1;
    kontrol("rst_sonuc", sonuc_o, 32'd0);
    kontrol("rst_bitti", {31'd0, bitti_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    for (int i = 0; i < NV; i++) begin
      calistir(v_islem[i], v_a[i], v_b[i], v_q[i], $sformatf("v%0d", i));
    end

    // Back-to-back with basla_i held; operands changed during the first op
    @(negedge clk_i);
    islem_i = 2'b00; bolunen_i = 32'd100; bolen_i = 32'd7; basla_i = 1'b1;
    @(posedge clk_i);
    #1;
    bolunen_i = 32'd200; bolen_i = 32'd3;
    bekle(n);
    kontrol("b2b_lat1", 32'(n), 32'd32);
    kontrol("b2b_res1", sonuc_o, 32'd14);
    @(posedge clk_i);
    #1;
    bekle(n);
    kontrol("b2b_lat2", 32'(n + 1), 32'd33);
    kontrol("b2b_res2", sonuc_o, 32'd66);
    basla_i = 1'b0;

    // Reset in the middle of an operation
    @(negedge clk_i);
    islem_i = 2'b00; bolunen_i = 32'd41; bolen_i = 32'd9; basla_i = 1'b1;
    @(posedge clk_i);
    #1;
    basla_i = 1'b0;
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    kontrol("mid_rst_sonuc", sonuc_o, 32'd0);
    kontrol("mid_rst_bitti", {31'd0, bitti_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    darbe = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk_i);
      #1;
      if (bitti_o === 1'b1) darbe++;
    end
    kontrol("mid_rst_stray", 32'(darbe), 32'd0);
    kontrol("mid_rst_hold", sonuc_o, 32'd0);

    calistir(2'b00, 32'd41, 32'd9, 32'd4, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks_s, errors_s);
    $finish;
  end

endmodule
